// File: rtl/mul_div_if.sv
// mul_div_if: command/result bundle between the control unit and the multiply/divide unit.
interface mul_div_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             hiWrite;
    logic             loWrite;
    logic [WIDTH-1:0] writeData;
    logic             busy;
    logic             done;
    logic             divByZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operandA, operandB, hiWrite, loWrite, writeData,
        input  busy, done, divByZero, hi, lo
    );

    modport slave (
        input  start, op, operandA, operandB, hiWrite, loWrite, writeData,
        output busy, done, divByZero, hi, lo
    );

endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine with HI/LO result registers.
// Signed operations run on magnitudes; the sign is restored when the result is committed.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    mul_div_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             r_state;
    logic               r_is_div;
    logic [WIDTH-1:0]   r_opnd;    // mult: |multiplicand|, div: |divisor|
    logic [2*WIDTH-1:0] r_acc;     // mult: {partial, multiplier}, div: {remainder, dividend/quotient}
    logic [CntW-1:0]    r_cnt;
    logic               r_neg_lo;  // negate product / quotient at commit
    logic               r_neg_hi;  // negate remainder at commit
    logic               r_busy;
    logic               r_done;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_ge;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;

    // Operand conditioning, one step of each algorithm, and sign-corrected results
    always_comb begin
        w_accept   = bus.start && (r_state == StIdle) && !r_busy;
        w_last     = (r_cnt == CntW'(WIDTH - 1));
        w_a_neg    = !bus.op[0] && bus.operandA[WIDTH-1];
        w_b_neg    = !bus.op[0] && bus.operandB[WIDTH-1];
        w_abs_a    = w_a_neg ? -bus.operandA : bus.operandA;
        w_abs_b    = w_b_neg ? -bus.operandB : bus.operandB;
        // Shift-add: add multiplicand when the multiplier LSB is set, then shift right
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH + 1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        // Restoring divide: shift next dividend bit into the remainder, subtract if it fits
        w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
        w_ge       = (w_rem_sh >= {1'b0, r_opnd});
        w_sub      = w_rem_sh[WIDTH-1:0] - r_opnd;
        w_div_next = {(w_ge ? w_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
        w_prod     = r_neg_lo ? -r_acc : r_acc;
        // A zero divisor leaves the dividend in the remainder; the quotient is forced to all ones
        w_quot     = (r_opnd == {WIDTH{1'b0}}) ? {WIDTH{1'b1}}
                   : (r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
        w_rem      = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_is_div <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_busy <= (r_state != StIdle);
            r_done <= 1'b0;
            if (!r_busy) begin
                if (bus.hiWrite) r_hi <= bus.writeData;
                if (bus.loWrite) r_lo <= bus.writeData;
            end
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state  <= StRun;
                        r_is_div <= bus.op[1];
                        r_cnt    <= '0;
                        r_div0   <= 1'b0;
                        r_neg_lo <= w_a_neg ^ w_b_neg;
                        r_neg_hi <= w_a_neg;
                        if (bus.op[1]) begin
                            r_opnd <= w_abs_b;
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                        end else begin
                            r_opnd <= w_abs_a;
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                        end
                    end
                end
                StRun: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CntW'(1);
                    if (w_last) r_state <= StDone;
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b1;
                    if (r_is_div) begin
                        r_hi   <= w_rem;
                        r_lo   <= w_quot;
                        r_div0 <= (r_opnd == {WIDTH{1'b0}});
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.divByZero = r_div0;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of 32-bit and 8-bit instances against an
// arithmetic reference model.
module tb_mul_div_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mul_div_if #(.WIDTH(32)) bus32 ();
    mul_div_if #(.WIDTH(8))  bus8 ();

    mul_div_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));
    mul_div_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] m_hi [2];
    logic [63:0] m_lo [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input int w);
        return (w == 32) ? 0 : 1;
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] rd_hi(input int w);
        return (w == 32) ? 64'(bus32.hi) : 64'(bus8.hi);
    endfunction

    function automatic logic [63:0] rd_lo(input int w);
        return (w == 32) ? 64'(bus32.lo) : 64'(bus8.lo);
    endfunction

    function automatic logic rd_busy(input int w);
        return (w == 32) ? bus32.busy : bus8.busy;
    endfunction

    function automatic logic rd_done(input int w);
        return (w == 32) ? bus32.done : bus8.done;
    endfunction

    function automatic logic rd_dz(input int w);
        return (w == 32) ? bus32.divByZero : bus8.divByZero;
    endfunction

    task automatic drive(input int w, input logic st, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic hw, input logic lw,
                         input logic [31:0] wd);
        if (w == 32) begin
            bus32.start = st; bus32.op = op; bus32.operandA = a; bus32.operandB = b;
            bus32.hiWrite = hw; bus32.loWrite = lw; bus32.writeData = wd;
        end else begin
            bus8.start = st; bus8.op = op; bus8.operandA = a[7:0]; bus8.operandB = b[7:0];
            bus8.hiWrite = hw; bus8.loWrite = lw; bus8.writeData = wd[7:0];
        end
    endtask

    // Reference: interpret operands as integers, use native * / % (truncating, dividend-signed)
    function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [63:0] ehi,
                                  output logic [63:0] elo, output logic edz);
        logic [63:0] mask, ua, ub, p;
        longint      sa, sb, q, r;
        mask = mask_of(w);
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = longint'(ua);
        sb   = longint'(ub);
        if (!op[0]) begin
            if (ua[w-1]) sa = sa - longint'(64'd1 << w);
            if (ub[w-1]) sb = sb - longint'(64'd1 << w);
        end
        edz = 1'b0;
        if (!op[1]) begin
            p   = sa * sb;
            elo = p & mask;
            ehi = (p >> w) & mask;
        end else if (ub == 64'd0) begin
            elo = mask;
            ehi = ua;
            edz = 1'b1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            elo = q & mask;
            ehi = r & mask;
        end
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'd1 << (w - 1);
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return 32'(v & mask_of(w));
    endfunction

    // One full operation: start, optional coincident MTLO, optional ignored start+MTLO mid-run
    task automatic issue(input int w, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic co_wr, input logic intrude);
        logic [63:0] ehi, elo;
        logic        edz;
        int          n;
        int          i;
        i = idx_of(w);
        model(w, op, a, b, ehi, elo, edz);
        n = 0;
        while (rd_busy(w) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_start", 64'(rd_busy(w)), 64'd0);
        drive(w, 1'b1, op, a, b, 1'b0, co_wr, 32'h5A5A_A5A5);
        @(negedge clk);
        drive(w, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        if (co_wr) begin
            m_lo[i] = 64'h5A5A_A5A5 & mask_of(w);
            check("co_start_lo_write", rd_lo(w), m_lo[i]);
        end
        n = 0;
        while (!rd_done(w) && n < 3 * w) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("busy_in_run", 64'(rd_busy(w)), 64'd1);
                check("dz_cleared_at_start", 64'(rd_dz(w)), 64'd0);
            end
            if (intrude && n == 5) drive(w, 1'b1, 2'b11, 32'd100, 32'd3, 1'b1, 1'b1, 32'hDEAD_BEEF);
            if (intrude && n == 6) begin
                drive(w, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
                check("busy_write_ignored_lo", rd_lo(w), m_lo[i]);
                check("busy_write_ignored_hi", rd_hi(w), m_hi[i]);
            end
        end
        check("latency", 64'(n), 64'(w + 1));
        check("lo", rd_lo(w), elo);
        check("hi", rd_hi(w), ehi);
        check("div_by_zero", 64'(rd_dz(w)), 64'(edz));
        check("busy_at_done", 64'(rd_busy(w)), 64'd1);
        m_hi[i] = ehi;
        m_lo[i] = elo;
        @(negedge clk);
        check("done_one_cycle", 64'(rd_done(w)), 64'd0);
        check("busy_dropped", 64'(rd_busy(w)), 64'd0);
        check("hi_hold", rd_hi(w), m_hi[i]);
        check("dz_hold", 64'(rd_dz(w)), 64'(edz));
    endtask

    task automatic mtx(input int w, input logic hw, input logic lw, input logic [31:0] d);
        int i;
        i = idx_of(w);
        drive(w, 1'b0, 2'b00, 32'd0, 32'd0, hw, lw, d);
        @(negedge clk);
        drive(w, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        if (hw) m_hi[i] = {32'd0, d} & mask_of(w);
        if (lw) m_lo[i] = {32'd0, d} & mask_of(w);
        check("mt_hi", rd_hi(w), m_hi[i]);
        check("mt_lo", rd_lo(w), m_lo[i]);
    endtask

    // Watch for spurious activity over a window
    task automatic quiet(input int w, input int cycles);
        int pulses;
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (rd_done(w) || rd_busy(w)) pulses++;
        end
        check("no_spurious_activity", 64'(pulses), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] op;
        drive(32, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        drive(8, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 2; j++) begin
            m_hi[j] = 64'd0;
            m_lo[j] = 64'd0;
        end
        for (int j = 0; j < 2; j++) begin
            check("reset_busy", 64'(rd_busy(j == 0 ? 32 : 8)), 64'd0);
            check("reset_done", 64'(rd_done(j == 0 ? 32 : 8)), 64'd0);
            check("reset_dz", 64'(rd_dz(j == 0 ? 32 : 8)), 64'd0);
            check("reset_hi", rd_hi(j == 0 ? 32 : 8), 64'd0);
            check("reset_lo", rd_lo(j == 0 ? 32 : 8), 64'd0);
        end

        // Directed arithmetic cases
        issue(32, 2'b01, 32'd23, 32'd67, 1'b0, 1'b0);
        check("multu_23x67_lo", rd_lo(32), 64'd1541);
        issue(32, 2'b00, 32'hFFFF_FFD4, 32'd23, 1'b0, 1'b0);
        check("mult_neg44x23_hi", rd_hi(32), 64'hFFFF_FFFF);
        issue(32, 2'b11, 32'd90, 32'd7, 1'b0, 1'b0);
        issue(32, 2'b10, 32'hFFFF_FFA6, 32'd7, 1'b0, 1'b0);
        check("div_neg90_7_lo", rd_lo(32), 64'hFFFF_FFF4);
        issue(32, 2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
        check("div5_0_dz", 64'(rd_dz(32)), 64'd1);
        issue(32, 2'b11, 32'd8, 32'd2, 1'b0, 1'b0);
        check("divu8_2_lo", rd_lo(32), 64'd4);
        issue(32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(32, 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);

        // MTHI / MTLO while idle, singly and together
        mtx(32, 1'b1, 1'b0, 32'h1234_5678);
        mtx(32, 1'b0, 1'b1, 32'h9ABC_DEF0);
        mtx(32, 1'b1, 1'b1, 32'h0F0F_F0F0);

        // MTLO coincident with start, then start+MTLO while busy
        issue(32, 2'b01, 32'd1000, 32'd3, 1'b1, 1'b0);
        issue(32, 2'b00, 32'd77, 32'hFFFF_FFF0, 1'b0, 1'b1);
        quiet(32, 45);

        // Reset at iteration 10 discards the operation
        drive(32, 1'b1, 2'b01, 32'd1234, 32'd77, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        drive(32, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (10) @(negedge clk);
        check("busy_before_reset", 64'(rd_busy(32)), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 2; j++) begin
            m_hi[j] = 64'd0;
            m_lo[j] = 64'd0;
        end
        check("midrun_reset_busy", 64'(rd_busy(32)), 64'd0);
        check("midrun_reset_hi", rd_hi(32), 64'd0);
        check("midrun_reset_lo", rd_lo(32), 64'd0);
        quiet(32, 45);

        // 8-bit instance
        issue(8, 2'b01, 32'd255, 32'd255, 1'b0, 1'b0);
        check("w8_multu_hi", rd_hi(8), 64'hFE);
        issue(8, 2'b10, 32'h80, 32'hFF, 1'b0, 1'b0);
        check("w8_div_min_lo", rd_lo(8), 64'h80);
        issue(8, 2'b10, 32'hF3, 32'd0, 1'b0, 1'b0);

        // Randomized operations on both widths
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            issue(32, op, pick(32), pick(32), 1'b0, 1'b0);
        end
        for (int k = 0; k < 30; k++) begin
            op = 2'($urandom_range(0, 3));
            issue(8, op, pick(8), pick(8), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
